// File: rtl/mac_seq_ctrl_pkg.sv
// Shared definitions for the MAC dot-product sequencer.
// Contents: default widths, FSM state encoding, pipeline latencies and the
// derived drain length/counter width used by mac_seq_ctrl.
package mac_seq_ctrl_pkg;

    // Default widths; DATA_W must match the MAC cell's data width.
    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 10;
    localparam int unsigned DEF_LEN_W  = 8;

    // Registered MAC result latency and operand buffer read latency.
    localparam int unsigned MAC_LAT = 1;
    localparam int unsigned RD_LAT  = 1;

    // Cycles between the last read strobe and its sum appearing on mac_out.
    localparam int unsigned DRAIN_LEN   = MAC_LAT + RD_LAT;
    localparam int unsigned DRAIN_CNT_W = $clog2(DRAIN_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Bundle between the sequencer and its environment (layer scheduler,
// operand buffers, MAC cell and result consumer).
//   start/len/a_base/b_base/bias : job request from the scheduler
//   busy                         : sequencer not idle
//   rd_en/rd_a_addr/rd_b_addr    : read port to feature/weight buffers
//   rd_a_data/rd_b_data          : buffer read data, 1 cycle after rd_en
//   mac_a/mac_b/mac_tmp/mac_ce   : MAC operands, addend and qualifier
//   mac_out                      : MAC registered result
//   result/result_valid/result_ready : dot-product output handshake
// slave  = sequencer view, master = environment view.
interface mac_seq_ctrl_if
    import mac_seq_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned LEN_W  = DEF_LEN_W
) ();

    // Job request
    logic              start;
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] a_base;
    logic [ADDR_W-1:0] b_base;
    logic [DATA_W-1:0] bias;
    logic              busy;

    // Operand buffer read port
    logic              rd_en;
    logic [ADDR_W-1:0] rd_a_addr;
    logic [ADDR_W-1:0] rd_b_addr;
    logic [DATA_W-1:0] rd_a_data;
    logic [DATA_W-1:0] rd_b_data;

    // MAC cell
    logic [DATA_W-1:0] mac_a;
    logic [DATA_W-1:0] mac_b;
    logic [DATA_W-1:0] mac_tmp;
    logic              mac_ce;
    logic [DATA_W-1:0] mac_out;

    // Result handshake
    logic [DATA_W-1:0] result;
    logic              result_valid;
    logic              result_ready;

    modport slave (
        input  start, len, a_base, b_base, bias,
        input  rd_a_data, rd_b_data, mac_out, result_ready,
        output busy, rd_en, rd_a_addr, rd_b_addr,
        output mac_a, mac_b, mac_tmp, mac_ce,
        output result, result_valid
    );

    modport master (
        output start, len, a_base, b_base, bias,
        output rd_a_data, rd_b_data, mac_out, result_ready,
        input  busy, rd_en, rd_a_addr, rd_b_addr,
        input  mac_a, mac_b, mac_tmp, mac_ce,
        input  result, result_valid
    );

endinterface

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: drives one shared registered MAC cell through
// out = bias + sum(a[i]*b[i]) over len elements read from two operand
// buffers, then presents the sum on a valid/ready output.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-low reset; aborts any job without a result
//   bus  : mac_seq_ctrl_if.slave (job request, buffer read port, MAC
//          operand/result, result handshake)
// mac_a/mac_b/mac_tmp/mac_ce are driven combinationally from the returning
// buffer data so the MAC accumulates back-to-back at one element per cycle.
module mac_seq_ctrl
    import mac_seq_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned LEN_W  = DEF_LEN_W
) (
    input  logic          clk,
    input  logic          rst,
    mac_seq_ctrl_if.slave bus
);

    state_e                 state_q;
    logic [LEN_W-1:0]       len_q;
    logic [LEN_W-1:0]       i_q;        // index of the address currently issued
    logic [DATA_W-1:0]      bias_q;
    logic [DRAIN_CNT_W-1:0] drain_q;

    logic                   busy_q;
    logic                   rd_en_q;
    logic [ADDR_W-1:0]      rd_a_addr_q;
    logic [ADDR_W-1:0]      rd_b_addr_q;
    logic [DATA_W-1:0]      result_q;
    logic                   result_valid_q;

    // Returning-data tracking: read strobe and first-element flag, delayed
    // by the buffer read latency.
    logic                   vld_q;
    logic                   first_q;

    logic [DATA_W-1:0]      mac_a_c;
    logic [DATA_W-1:0]      mac_b_c;
    logic [DATA_W-1:0]      mac_tmp_c;
    logic                   mac_ce_c;

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            len_q          <= '0;
            i_q            <= '0;
            bias_q         <= '0;
            drain_q        <= '0;
            busy_q         <= 1'b0;
            rd_en_q        <= 1'b0;
            rd_a_addr_q    <= '0;
            rd_b_addr_q    <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            vld_q          <= 1'b0;
            first_q        <= 1'b0;
        end else begin
            vld_q   <= rd_en_q;
            first_q <= rd_en_q && (i_q == '0);

            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (bus.len == '0) begin
                            // Empty dot product: the bias is the answer.
                            result_q       <= bus.bias;
                            result_valid_q <= 1'b1;
                            state_q        <= ST_DONE;
                        end else begin
                            len_q       <= bus.len;
                            bias_q      <= bus.bias;
                            i_q         <= '0;
                            rd_en_q     <= 1'b1;
                            rd_a_addr_q <= bus.a_base;
                            rd_b_addr_q <= bus.b_base;
                            state_q     <= ST_RUN;
                        end
                    end
                end

                ST_RUN: begin
                    if (i_q == len_q - LEN_W'(1)) begin
                        rd_en_q <= 1'b0;
                        drain_q <= DRAIN_CNT_W'(DRAIN_LEN - 1);
                        state_q <= ST_DRAIN;
                    end else begin
                        // Address increment wraps naturally at 2^ADDR_W.
                        i_q         <= i_q + LEN_W'(1);
                        rd_a_addr_q <= rd_a_addr_q + ADDR_W'(1);
                        rd_b_addr_q <= rd_b_addr_q + ADDR_W'(1);
                    end
                end

                ST_DRAIN: begin
                    // Last element's sum is on mac_out once drain_q reaches 0.
                    if (drain_q == '0) begin
                        result_q       <= bus.mac_out;
                        result_valid_q <= 1'b1;
                        state_q        <= ST_DONE;
                    end else begin
                        drain_q <= drain_q - DRAIN_CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    // A start in the accepting cycle is dropped; earliest
                    // accept is the following cycle from IDLE.
                    if (bus.result_ready) begin
                        result_valid_q <= 1'b0;
                        busy_q         <= 1'b0;
                        state_q        <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // MAC input steering: bias seeds the first element, the MAC's own
    // registered output feeds every later element.
    always_comb begin
        mac_a_c   = '0;
        mac_b_c   = '0;
        mac_tmp_c = '0;
        mac_ce_c  = 1'b0;
        if (vld_q) begin
            mac_ce_c  = 1'b1;
            mac_a_c   = bus.rd_a_data;
            mac_b_c   = bus.rd_b_data;
            mac_tmp_c = first_q ? bias_q : bus.mac_out;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.rd_en        = rd_en_q;
    assign bus.rd_a_addr    = rd_a_addr_q;
    assign bus.rd_b_addr    = rd_b_addr_q;
    assign bus.mac_a        = mac_a_c;
    assign bus.mac_b        = mac_b_c;
    assign bus.mac_tmp      = mac_tmp_c;
    assign bus.mac_ce       = mac_ce_c;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a registered MAC cell model and two
// 1-cycle-latency operand buffer models. Inputs change 1 time unit after
// the rising edge; outputs are sampled at the same point.
module tb_mac_seq_ctrl;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned LEN_W  = 8;

    logic clk;
    logic rst;

    mac_seq_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    mac_seq_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DATA_W-1:0] mem_a [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] mem_b [0:(1<<ADDR_W)-1];

    // Operand buffers: registered read, data held when not strobed.
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.rd_a_data <= mem_a[bus.rd_a_addr];
            bus.rd_b_data <= mem_b[bus.rd_b_addr];
        end
    end

    // Registered MAC cell: truncating multiply-add, registers every cycle.
    always @(posedge clk) begin
        bus.mac_out <= DATA_W'(bus.mac_a * bus.mac_b + bus.mac_tmp);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;
    int busy_cnt;
    int rv_first;
    int rv_cnt;
    int rd_cnt;
    int stable_bad;
    logic [DATA_W-1:0] res_last;
    logic [ADDR_W-1:0] a_seq [0:7];
    logic [ADDR_W-1:0] b_seq [0:7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        busy_cnt   = 0;
        rv_first   = -1;
        rv_cnt     = 0;
        rd_cnt     = 0;
        stable_bad = 0;
        res_last   = '0;
    endtask

    task automatic sample(input int k);
        if (bus.busy) busy_cnt++;
        if (bus.result_valid) begin
            if (rv_first < 0) rv_first = k;
            rv_cnt++;
            res_last = bus.result;
        end
        if (bus.rd_en) begin
            if (rd_cnt < 8) begin
                a_seq[rd_cnt] = bus.rd_a_addr;
                b_seq[rd_cnt] = bus.rd_b_addr;
            end
            rd_cnt++;
        end
    endtask

    task automatic launch(input logic [LEN_W-1:0] len, input logic [ADDR_W-1:0] ab,
                          input logic [ADDR_W-1:0] bb, input logic [DATA_W-1:0] bias);
        bus.start  = 1'b1;
        bus.len    = len;
        bus.a_base = ab;
        bus.b_base = bb;
        bus.bias   = bias;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        clear_stats();
        for (int j = 0; j < (1 << ADDR_W); j++) begin
            mem_a[j] = '0;
            mem_b[j] = '0;
        end
        mem_a[10'h000] = 16'd1;  mem_a[10'h001] = 16'd2;  mem_a[10'h002] = 16'd3;
        mem_b[10'h100] = 16'd4;  mem_b[10'h101] = 16'd5;  mem_b[10'h102] = 16'd6;
        mem_a[10'h010] = 16'h0100; mem_a[10'h011] = 16'h0100;
        mem_b[10'h020] = 16'h0100; mem_b[10'h021] = 16'h0001;
        mem_a[10'h030] = 16'd3;  mem_a[10'h031] = 16'd4;
        mem_b[10'h040] = 16'd5;  mem_b[10'h041] = 16'd6;
        mem_a[10'h3FE] = 16'd1;  mem_a[10'h3FF] = 16'd1;
        mem_b[10'h200] = 16'd1;  mem_b[10'h201] = 16'd1;
        mem_b[10'h202] = 16'd1;  mem_b[10'h203] = 16'd1;
        mem_a[10'h050] = 16'd7;  mem_b[10'h060] = 16'd3;

        bus.start        = 1'b0;
        bus.len          = '0;
        bus.a_base       = '0;
        bus.b_base       = '0;
        bus.bias         = '0;
        bus.result_ready = 1'b1;
        rst              = 1'b0;

        // Reset state
        tick(); tick(); tick();
        check("rst_busy",   32'(bus.busy), 32'd0);
        check("rst_rd_en",  32'(bus.rd_en), 32'd0);
        check("rst_mac_ce", 32'(bus.mac_ce), 32'd0);
        check("rst_rv",     32'(bus.result_valid), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_addr_a", 32'(bus.rd_a_addr), 32'd0);
        check("rst_mac_a",  32'(bus.mac_a), 32'd0);
        check("rst_mac_tmp",32'(bus.mac_tmp), 32'd0);
        rst = 1'b1;
        tick();

        // len=3: 10 + 1*4 + 2*5 + 3*6 = 42
        clear_stats();
        launch(8'd3, 10'h000, 10'h100, 16'd10);
        for (int k = 0; k <= 8; k++) begin
            tick();
            if (k == 0) bus.start = 1'b0;
            if (k == 1) begin
                check("t1_ce_e0",   32'(bus.mac_ce), 32'd1);
                check("t1_a_e0",    32'(bus.mac_a), 32'd1);
                check("t1_b_e0",    32'(bus.mac_b), 32'd4);
                check("t1_tmp_e0",  32'(bus.mac_tmp), 32'd10);
            end
            if (k == 2) check("t1_tmp_e1", 32'(bus.mac_tmp), 32'd14);
            sample(k);
        end
        check("t1_result",   32'(res_last), 32'd42);
        check("t1_rv_lat",   32'(rv_first), 32'd5);
        check("t1_rv_cnt",   32'(rv_cnt), 32'd1);
        check("t1_busy_cnt", 32'(busy_cnt), 32'd6);
        check("t1_rd_cnt",   32'(rd_cnt), 32'd3);

        // len=0: bias returned 1 cycle after start, no reads
        clear_stats();
        launch(8'd0, 10'h000, 10'h000, 16'h1234);
        for (int k = 0; k <= 3; k++) begin
            tick();
            if (k == 0) bus.start = 1'b0;
            sample(k);
        end
        check("t2_result", 32'(res_last), 32'h1234);
        check("t2_rv_lat", 32'(rv_first), 32'd0);
        check("t2_rv_cnt", 32'(rv_cnt), 32'd1);
        check("t2_rd_cnt", 32'(rd_cnt), 32'd0);

        // len=2 modulo wrap: 0x100*0x100 wraps to 0, + 0x100*1
        clear_stats();
        launch(8'd2, 10'h010, 10'h020, 16'd0);
        for (int k = 0; k <= 6; k++) begin
            tick();
            if (k == 0) bus.start = 1'b0;
            sample(k);
        end
        check("t3_result", 32'(res_last), 32'h0100);
        check("t3_rv_lat", 32'(rv_first), 32'd4);

        // Backpressure: ready low, starts during RUN and DONE ignored.
        // 1 + 3*5 + 4*6 = 40
        clear_stats();
        bus.result_ready = 1'b0;
        launch(8'd2, 10'h030, 10'h040, 16'd1);
        for (int k = 0; k <= 14; k++) begin
            tick();
            bus.start = 1'b0;
            if (k == 1 || k == 8) launch(8'd0, 10'h000, 10'h000, 16'hBEEF);
            sample(k);
            if (k >= 4 && bus.result !== 16'h0028) stable_bad++;
        end
        bus.start = 1'b0;
        check("t4_rv_lat",  32'(rv_first), 32'd4);
        check("t4_rv_hold", 32'(rv_cnt), 32'd11);
        check("t4_stable",  32'(stable_bad), 32'd0);
        check("t4_busy",    32'(busy_cnt), 32'd15);
        bus.result_ready = 1'b1;
        launch(8'd0, 10'h000, 10'h000, 16'h5555);
        tick();
        check("t4_rel_rv",   32'(bus.result_valid), 32'd0);
        check("t4_rel_busy", 32'(bus.busy), 32'd0);
        tick();
        bus.start = 1'b0;
        check("t4_next_rv",  32'(bus.result_valid), 32'd1);
        check("t4_next_res", 32'(bus.result), 32'h5555);
        tick();
        check("t4_idle", 32'(bus.busy), 32'd0);

        // Address wrap: a_base=0x3FE, len=4; 1+1+1+2 = 5
        clear_stats();
        launch(8'd4, 10'h3FE, 10'h200, 16'd0);
        for (int k = 0; k <= 8; k++) begin
            tick();
            if (k == 0) bus.start = 1'b0;
            sample(k);
        end
        check("t5_rd_cnt", 32'(rd_cnt), 32'd4);
        check("t5_a0", 32'(a_seq[0]), 32'h3FE);
        check("t5_a1", 32'(a_seq[1]), 32'h3FF);
        check("t5_a2", 32'(a_seq[2]), 32'h000);
        check("t5_a3", 32'(a_seq[3]), 32'h001);
        check("t5_b3", 32'(b_seq[3]), 32'h203);
        check("t5_result", 32'(res_last), 32'd5);
        check("t5_rv_lat", 32'(rv_first), 32'd6);

        // Reset mid-RUN at i=4 of len=8
        launch(8'd8, 10'h070, 10'h080, 16'hAAAA);
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick(); tick();
        check("t6_pre_rd_en", 32'(bus.rd_en), 32'd1);
        check("t6_pre_addr",  32'(bus.rd_a_addr), 32'h074);
        rst = 1'b0;
        #1;
        check("t6_busy",   32'(bus.busy), 32'd0);
        check("t6_rd_en",  32'(bus.rd_en), 32'd0);
        check("t6_addr",   32'(bus.rd_a_addr), 32'd0);
        check("t6_mac_ce", 32'(bus.mac_ce), 32'd0);
        check("t6_mac_a",  32'(bus.mac_a), 32'd0);
        check("t6_rv",     32'(bus.result_valid), 32'd0);
        tick(); tick();
        rst = 1'b1;
        tick();
        // Fresh job: 1 + 7*3 = 22
        clear_stats();
        launch(8'd1, 10'h050, 10'h060, 16'd1);
        for (int k = 0; k <= 5; k++) begin
            tick();
            if (k == 0) bus.start = 1'b0;
            sample(k);
        end
        check("t6_result", 32'(res_last), 32'd22);
        check("t6_rv_lat", 32'(rv_first), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
